seq_detect_ctrl: RTL and testbench

Controller that feeds a programmable serial pattern detector from a parallel word stream and tallies detections. It accepts WORD_W-bit words over a valid/ready handshake and shifts each word MSB-first into an internal matcher, one bit per clock. The target pattern and length are loaded through a small configuration port. The block keeps a saturating match counter and raises a sticky interrupt at a programmable threshold. It sits between the bus-side data source and the interrupt/status logic.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/pattern_matcher.sv | 49 ++++
 rtl/seq_detect_ctrl.sv | 116 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding and length helpers for the sequence detector
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A length of zero or beyond the history width means "use the full history".
  function automatic int clamp_len(input int len, input int pat_w);
    return (len == 0 || len > pat_w) ? pat_w : len;
  endfunction

  // One bit of mask(len): history bit idx takes part in the compare.
  function automatic logic mask_bit(input int idx, input int len);
    return (idx < len);
  endfunction

endpackage

// File: rtl/pattern_matcher.sv
// rtl/pattern_matcher.sv - bit history, fill tracking and masked pattern compare
module pattern_matcher
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             shift_en,
  input  logic             clear,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             match
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_next;

  for (genvar i = 0; i < PAT_W; i++) begin : g_mask
    assign mask[i] = mask_bit(i, int'(len));
  end

  assign hist_next = {hist[PAT_W-2:0], bit_in};
  assign fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;

  // Compare against the history as it will be after this bit lands.
  assign match = shift_en
              && (((hist_next ^ pattern) & mask) == '0)
              && (fill_next >= len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_next;
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - word serialiser, config registers, match counter and sticky IRQ
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = $clog2(PAT_W) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CFG_WE,
  input  logic [PAT_W-1:0]  CFG_PATTERN,
  input  logic [LEN_W-1:0]  CFG_LEN,
  input  logic [CNT_W-1:0]  CFG_THRESH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [WORD_W-1:0] IN_DATA,
  input  logic              CLR_CNT,
  output logic              BUSY,
  output logic              MATCH,
  output logic [CNT_W-1:0]  MATCH_CNT,
  output logic              IRQ
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic [PAT_W-1:0]  pattern_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  thresh_q;
  logic              cfg_load;
  logic              accept;
  logic              shift_en;
  logic              hit;
  logic [CNT_W-1:0]  cnt_next;

  assign IN_READY = (state == IDLE);
  assign BUSY     = (state == SHIFT);
  assign accept   = IN_VALID && IN_READY;
  assign cfg_load = CFG_WE && (state == IDLE);
  assign shift_en = (state == SHIFT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      pattern_q <= '0;
      len_q     <= LEN_W'(PAT_W);
      thresh_q  <= '0;
    end else begin
      if (cfg_load) begin
        pattern_q <= CFG_PATTERN;
        len_q     <= LEN_W'(clamp_len(int'(CFG_LEN), PAT_W));
        thresh_q  <= CFG_THRESH;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= IN_DATA;
            idx   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= {shreg[WORD_W-2:0], 1'b0};
          idx   <= idx + 1'b1;
          if (idx == IDX_W'(WORD_W - 1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pattern_matcher #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_matcher (
    .clk     (CLK),
    .rst     (RST),
    .bit_in  (shreg[WORD_W-1]),
    .shift_en(shift_en),
    .clear   (cfg_load),
    .pattern (pattern_q),
    .len     (len_q),
    .match   (hit)
  );

  assign cnt_next = (MATCH_CNT == '1) ? MATCH_CNT : MATCH_CNT + 1'b1;

  // A clear in the same cycle as a hit wins; the MATCH pulse itself still fires.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MATCH     <= 1'b0;
      MATCH_CNT <= '0;
      IRQ       <= 1'b0;
    end else begin
      MATCH <= hit;
      if (CLR_CNT) begin
        MATCH_CNT <= '0;
        IRQ       <= 1'b0;
      end else if (hit) begin
        MATCH_CNT <= cnt_next;
        if (thresh_q != '0 && cnt_next == thresh_q) begin
          IRQ <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CFG_WE = 1'b0;
  logic [7:0] CFG_PATTERN = '0;
  logic [3:0] CFG_LEN = '0;
  logic [7:0] CFG_THRESH = '0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] IN_DATA = '0;
  logic       CLR_CNT = 1'b0;
  logic       BUSY;
  logic       MATCH;
  logic [7:0] MATCH_CNT;
  logic       IRQ;

  int checks = 0;
  int failures = 0;

  seq_detect_ctrl #(.WORD_W(8), .PAT_W(8), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_PATTERN(CFG_PATTERN),
    .CFG_LEN(CFG_LEN), .CFG_THRESH(CFG_THRESH), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .IN_DATA(IN_DATA), .CLR_CNT(CLR_CNT), .BUSY(BUSY),
    .MATCH(MATCH), .MATCH_CNT(MATCH_CNT), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] thr);
    CFG_WE = 1'b1; CFG_PATTERN = pat; CFG_LEN = len; CFG_THRESH = thr;
    tick();
    CFG_WE = 1'b0;
  endtask

  task automatic clr();
    CLR_CNT = 1'b1;
    tick();
    CLR_CNT = 1'b0;
  endtask

  // Sends one word and returns which bit positions k produced a MATCH pulse.
  task automatic send_word(input logic [7:0] w, output logic [7:0] mask);
    mask = '0;
    IN_VALID = 1'b1; IN_DATA = w;
    tick();
    IN_VALID = 1'b0; IN_DATA = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      tick();
      mask[k] = MATCH;
    end
  endtask

  logic [7:0] m;
  int n;

  initial begin
    #12;
    @(negedge CLK);
    check("reset_ready", IN_READY, 1'b1);
    check("reset_busy", BUSY, 1'b0);
    check("reset_match", MATCH, 1'b0);
    check("reset_cnt", MATCH_CNT, 8'd0);
    check("reset_irq", IRQ, 1'b0);
    RST = 1'b0;
    tick();

    // Reset config: pattern 0, full length 8 -> first match only once 8 bits filled
    send_word(8'h00, m);
    check("t0_default_cfg_mask", m, 8'b1000_0000);
    check("t0_cnt", MATCH_CNT, 8'd1);
    clr();

    // Test 1
    cfg(8'b100, 4'd3, 8'd0);
    send_word(8'b1001_0010, m);
    check("t1_mask", m, 8'b0010_0100);
    check("t1_cnt", MATCH_CNT, 8'd2);
    check("t1_irq", IRQ, 1'b0);
    clr();

    // Test 2: overlapping
    cfg(8'b101, 4'd3, 8'd0);
    send_word(8'b1010_1010, m);
    check("t2_mask", m, 8'b0101_0100);
    check("t2_cnt", MATCH_CNT, 8'd3);
    clr();

    // Test 3: cross-word match
    cfg(8'b100, 4'd3, 8'd0);
    send_word(8'b0000_0010, m);
    check("t3_w1_mask", m, 8'b0000_0000);
    send_word(8'b0111_1111, m);
    check("t3_w2_mask", m, 8'b0000_0001);
    check("t3_cnt", MATCH_CNT, 8'd1);
    clr();

    // Test 3b: fill gating with all-zero pattern
    cfg(8'b000, 4'd3, 8'd0);
    send_word(8'h00, m);
    check("t3b_fill_mask", m, 8'b1111_1100);
    clr();

    // Length clamp: LEN=0 behaves as 8
    cfg(8'hFF, 4'd0, 8'd0);
    send_word(8'hFF, m);
    check("clamp_len0_mask", m, 8'b1000_0000);
    cfg(8'hFF, 4'd12, 8'd0);
    send_word(8'hFF, m);
    check("clamp_len12_mask", m, 8'b1000_0000);
    clr();

    // Test 4: threshold IRQ, then clear colliding with a match
    cfg(8'b1, 4'd1, 8'd2);
    IN_VALID = 1'b1; IN_DATA = 8'b1100_0000;
    tick();
    IN_VALID = 1'b0;
    tick();
    check("t4_first_match", MATCH, 1'b1);
    check("t4_irq_before", IRQ, 1'b0);
    tick();
    check("t4_second_match", MATCH, 1'b1);
    check("t4_irq_rise", IRQ, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("t4_irq_sticky", IRQ, 1'b1);
    check("t4_cnt", MATCH_CNT, 8'd2);
    IN_VALID = 1'b1; IN_DATA = 8'b1000_0000;
    tick();
    IN_VALID = 1'b0;
    CLR_CNT = 1'b1;
    tick();
    CLR_CNT = 1'b0;
    check("t4_clr_match_pulse", MATCH, 1'b1);
    check("t4_clr_cnt", MATCH_CNT, 8'd0);
    check("t4_clr_irq", IRQ, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("t4_after_cnt", MATCH_CNT, 8'd0);

    // Test 5: config ignored while busy; back-to-back throughput
    cfg(8'b111, 4'd3, 8'd0);
    clr();
    IN_VALID = 1'b1; IN_DATA = 8'b0000_0111;
    tick();
    IN_DATA = 8'h00;
    CFG_WE = 1'b1; CFG_PATTERN = 8'b000; CFG_LEN = 4'd3; CFG_THRESH = 8'd0;
    n = 0;
    while (!IN_READY && n < 20) begin
      tick();
      n++;
    end
    CFG_WE = 1'b0;
    check("t5_ready_low_cycles", n, 8);
    check("t5_match_k7", MATCH, 1'b1);
    check("t5_cnt_a", MATCH_CNT, 8'd1);
    tick();
    check("t5_second_accepted", BUSY, 1'b1);
    IN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("t5_cnt_b", MATCH_CNT, 8'd1);
    check("t5_ready", IN_READY, 1'b1);

    // Saturation: 256 single-bit matches into an 8-bit counter
    cfg(8'b1, 4'd1, 8'd0);
    clr();
    for (int w = 0; w < 32; w++) send_word(8'hFF, m);
    check("sat_cnt", MATCH_CNT, 8'hFF);
    clr();

    // Test 6: async reset mid-word during bit k=3
    IN_VALID = 1'b1; IN_DATA = 8'hFF;
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t6_pre_match", MATCH, 1'b1);
    check("t6_pre_cnt", MATCH_CNT, 8'd3);
    #2 RST = 1'b1;
    #1;
    check("t6_rst_busy", BUSY, 1'b0);
    check("t6_rst_match", MATCH, 1'b0);
    check("t6_rst_cnt", MATCH_CNT, 8'd0);
    check("t6_rst_irq", IRQ, 1'b0);
    check("t6_rst_ready", IN_READY, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t6_post_cnt", MATCH_CNT, 8'd0);
    check("t6_post_busy", BUSY, 1'b0);
    send_word(8'h00, m);
    check("t6_cfg_reset_mask", m, 8'b1000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
